// File: rtl/dz_matrix_scan_pkg.sv
// Shared types and helpers for the bicolour LED matrix scanner.
package dz_pkg;

  localparam int MAX_ROWS = 64;
  localparam int COLS_MAX = 64;
  localparam logic ROW_ACTIVE_LOW_DEF = 1'b1;

  typedef struct packed {
    logic [COLS_MAX-1:0] colr;
    logic [COLS_MAX-1:0] colg;
  } row_t;

  // One-hot row select; active_low inverts so the selected row is the only 0.
  function automatic logic [MAX_ROWS-1:0] row_select(input int unsigned idx, input logic active_low);
    logic [MAX_ROWS-1:0] v;
    v = MAX_ROWS'(1) << idx;
    return active_low ? ~v : v;
  endfunction

endpackage

// File: rtl/dz_matrix_scan_timer.sv
// Scan timing: prescaler, row counter, frame tick and frame-synchronous blink phase.
module dz_scan_timer #(
  parameter int ROWS         = 8,
  parameter int SCAN_DIV     = 1,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    blink_en,
  output logic                    step,
  output logic [$clog2(ROWS)-1:0] row_idx,
  output logic                    frame_tick,
  output logic                    phase
);
  import dz_pkg::*;

  localparam int RW = $clog2(ROWS);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0] presc;
  logic [FW-1:0] fcnt;

  assign step       = (presc == PW'(SCAN_DIV - 1));
  assign frame_tick = step && (row_idx == RW'(ROWS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc   <= '0;
      row_idx <= '0;
      fcnt    <= '0;
      phase   <= 1'b0;
    end else begin
      presc <= step ? '0 : presc + 1'b1;
      if (step)
        row_idx <= (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
      // Blink state is parked at zero while disabled so re-enabling starts visible.
      if (!blink_en) begin
        fcnt  <= '0;
        phase <= 1'b0;
      end else if (frame_tick) begin
        if (fcnt == FW'(BLINK_FRAMES - 1)) begin
          fcnt  <= '0;
          phase <= ~phase;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dz_matrix_scan.sv
// Double-buffered row-scanning driver for a ROWS x COLS red/green LED matrix.
module dz_matrix_scan #(
  parameter int ROWS           = 8,
  parameter int COLS           = 8,
  parameter int SCAN_DIV       = 1,
  parameter int BLINK_FRAMES   = 32,
  parameter int ROW_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [COLS-1:0]         wr_colr,
  input  logic [COLS-1:0]         wr_colg,
  input  logic                    swap_req,
  output logic                    swap_ack,
  input  logic                    blink_en,
  input  logic                    blank,
  output logic [ROWS-1:0]         row,
  output logic [COLS-1:0]         colr,
  output logic [COLS-1:0]         colg,
  output logic                    frame_start
);
  import dz_pkg::*;

  localparam int   RW      = $clog2(ROWS);
  localparam logic ACT_LOW = (ROW_ACTIVE_LOW != 0);

  logic          step, frame_tick, phase, mask;
  logic [RW-1:0] row_idx;
  logic          front, pending, flipped, row_start;
  row_t          bank [2][ROWS];

  dz_scan_timer #(
    .ROWS        (ROWS),
    .SCAN_DIV    (SCAN_DIV),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .blink_en  (blink_en),
    .step      (step),
    .row_idx   (row_idx),
    .frame_tick(frame_tick),
    .phase     (phase)
  );

  assign mask = blank | (blink_en & phase);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < ROWS; r++)
          bank[b][r] <= '0;
      front       <= 1'b0;
      pending     <= 1'b0;
      flipped     <= 1'b0;
      row_start   <= 1'b1;
      swap_ack    <= 1'b0;
      row         <= {ROWS{ACT_LOW}};
      colr        <= '0;
      colg        <= '0;
      frame_start <= 1'b0;
    end else begin
      // Writes use the pre-flip back bank, so a same-cycle write shows after the swap.
      if (wr_en && ({1'b0, wr_row} < (RW+1)'(ROWS)))
        bank[~front][wr_row] <= '{colr: COLS_MAX'(wr_colr), colg: COLS_MAX'(wr_colg)};
      if (frame_tick && pending) begin
        front   <= ~front;
        pending <= 1'b0;
      end else if (swap_req) begin
        pending <= 1'b1;
      end
      flipped   <= frame_tick && pending;
      swap_ack  <= flipped;
      row_start <= step;
      // Output registers: one cycle behind row_idx, row stays lit while columns are masked.
      row         <= ROWS'(row_select(32'(row_idx), ACT_LOW));
      colr        <= COLS'(bank[front][row_idx].colr) & ~{COLS{mask}};
      colg        <= COLS'(bank[front][row_idx].colg) & ~{COLS{mask}};
      frame_start <= row_start && (row_idx == '0);
    end
  end

endmodule

// File: tb/tb_dz_matrix_scan.sv
// Directed bench for dz_matrix_scan: scan order, swap handshake, blink, blank, reset.
module tb_dz_matrix_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_row = '0;
  logic [7:0] wr_colr = '0, wr_colg = '0;
  logic       swap_req = 1'b0, blink_en = 1'b0, blank = 1'b0;

  logic       ack, fs, ack2, fs2;
  logic [7:0] row, colr, colg, row2, colr2, colg2;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  always #5 clk = ~clk;

  dz_matrix_scan #(.BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_colr(wr_colr),
    .wr_colg(wr_colg), .swap_req(swap_req), .swap_ack(ack), .blink_en(blink_en),
    .blank(blank), .row(row), .colr(colr), .colg(colg), .frame_start(fs)
  );

  dz_matrix_scan #(.SCAN_DIV(4)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_colr(wr_colr),
    .wr_colg(wr_colg), .swap_req(swap_req), .swap_ack(ack2), .blink_en(blink_en),
    .blank(blank), .row(row2), .colr(colr2), .colg(colg2), .frame_start(fs2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] exp_row(input int r);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << r);
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Advance until the output register presents row r (always at least one clock).
  task automatic go_row(input int r);
    do tick(); while (((cyc - 1) % 8) != r);
  endtask

  task automatic wait_ack(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 24 && !seen; i++) begin
      tick();
      if (ack === 1'b1) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    int acks;

    #1 rst = 1'b1;
    #2;
    check("rst_row", 32'(row), 32'hFF);
    check("rst_colr", 32'(colr), 32'h00);
    check("rst_ack_fs", 32'({ack, fs}), 32'h0);
    check("rst_row2", 32'(row2), 32'hFF);
    @(negedge clk);
    @(negedge clk);
    check("rst_hold_row", 32'(row), 32'hFF);
    rst = 1'b0;
    cyc = 0;

    // Free scan from reset: dut one row per clock, dut2 four clocks per row.
    for (int k = 0; k < 40; k++) begin
      tick();
      check("scan_row", 32'(row), 32'(exp_row((cyc - 1) % 8)));
      check("scan_fs", 32'(fs), 32'(((cyc - 1) % 8) == 0));
      check("scan_cols", 32'({colr, colg}), 32'h0);
      check("div4_row", 32'(row2), 32'(exp_row(((cyc - 1) / 4) % 8)));
      check("div4_fs", 32'(fs2), 32'(((cyc - 1) % 32) == 0));
    end

    // Write back bank row 2; front must stay dark until a swap.
    wr_en = 1'b1; wr_row = 3'd2; wr_colr = 8'h3C; wr_colg = 8'h7E;
    tick();
    wr_en = 1'b0;
    go_row(2);
    check("noswap_row", 32'(row), 32'hFB);
    check("noswap_cols", 32'({colr, colg}), 32'h0);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    while (cyc < 48) tick();
    check("ack_early", 32'(ack), 32'd0);
    tick();
    check("ack_pulse", 32'(ack), 32'd1);
    check("ack_fs", 32'(fs), 32'd1);
    check("ack_row0", 32'(row), 32'hFE);
    tick();
    check("ack_drop", 32'(ack), 32'd0);
    go_row(2);
    check("swap_colr", 32'(colr), 32'h3C);
    check("swap_colg", 32'(colg), 32'h7E);

    // Two requests inside one frame give a single swap back to the empty bank.
    swap_req = 1'b1; tick();
    swap_req = 1'b0; tick();
    swap_req = 1'b1; tick();
    swap_req = 1'b0;
    acks = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (ack === 1'b1) acks++;
    end
    check("dbl_ack_count", 32'(acks), 32'd1);
    go_row(2);
    check("dbl_front_row2", 32'({colr, colg}), 32'h0);
    wr_en = 1'b1; wr_row = 3'd5; wr_colr = 8'hA5; wr_colg = 8'h5A;
    tick();
    wr_en = 1'b0;
    go_row(5);
    check("back_write_hidden", 32'({colr, colg}), 32'h0);
    swap_req = 1'b1; tick();
    swap_req = 1'b0;
    wait_ack("third_ack");
    go_row(2);
    check("third_row2", 32'({colr, colg}), 32'h3C7E);
    go_row(5);
    check("third_row5", 32'({colr, colg}), 32'hA55A);

    // Blink with two frames per half-period: visible, visible, dark, dark, visible, visible.
    go_row(7);
    blink_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      go_row(2);
      check("blink_row", 32'(row), 32'hFB);
      check("blink_cols", 32'({colr, colg}), (f == 2 || f == 3) ? 32'h0 : 32'h3C7E);
    end
    blink_en = 1'b0;

    go_row(1);
    blank = 1'b1;
    tick();
    check("blank_row", 32'(row), 32'hFB);
    check("blank_cols", 32'({colr, colg}), 32'h0);
    blank = 1'b0;
    go_row(2);
    check("unblank_cols", 32'({colr, colg}), 32'h3C7E);

    // Asynchronous reset mid-frame with a swap pending.
    swap_req = 1'b1; tick();
    swap_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_row", 32'(row), 32'hFF);
    check("arst_cols", 32'({colr, colg}), 32'h0);
    check("arst_ack_fs", 32'({ack, fs}), 32'h0);
    check("arst_row2", 32'(row2), 32'hFF);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    acks = 0;
    for (int k = 0; k < 24; k++) begin
      tick();
      if (ack === 1'b1) acks++;
      check("post_rst_row", 32'(row), 32'(exp_row((cyc - 1) % 8)));
      check("post_rst_cols", 32'({colr, colg}), 32'h0);
    end
    check("post_rst_no_ack", 32'(acks), 32'd0);
    swap_req = 1'b1; tick();
    swap_req = 1'b0;
    wait_ack("post_rst_swap");
    go_row(2);
    check("post_rst_bank_clear", 32'({colr, colg}), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dz_matrix_scan.md
Name: dz_matrix_scan

Overview:
Parametrised row-scanning driver for a bicolour (red/green) LED dot matrix of ROWS x COLS pixels.
- Holds a double-buffered frame store: the producer writes whole row patterns into the back bank and requests a swap.
- The swap takes effect only at a frame boundary, so the display never tears.
- Adds a programmable scan prescaler, a frame-synchronous blink mode and a blank input.
- Sits between the pattern generators (egg shapes, digits) and the board-level row/column pins.

Parameters:
ROWS, 8, number of matrix rows scanned (>=2)
COLS, 8, number of columns per colour
SCAN_DIV, 1, clk cycles per row step (>=1); 1 means one row per clk at 1 kHz
BLINK_FRAMES, 32, frames per blink half-period (>=1)
ROW_ACTIVE_LOW, 1, 1 = selected row driven 0, others 1; 0 = inverted

Ports:
clk  in  1  scan clock (1 kHz on board)
rst  in  1  asynchronous reset, active-high
wr_en  in  1  write row pattern into back bank this cycle
wr_row  in  $clog2(ROWS)  row index for write; values >= ROWS ignored
wr_colr  in  COLS  red column pattern, 1 = LED on
wr_colg  in  COLS  green column pattern, 1 = LED on
swap_req  in  1  single-cycle pulse: request back/front exchange
swap_ack  out  1  1-cycle pulse: swap performed
blink_en  in  1  enable blink mode
blank  in  1  force all columns off (level)
row  out  ROWS  one-hot row select, polarity per ROW_ACTIVE_LOW
colr  out  COLS  red columns for the current row
colg  out  COLS  green columns for the current row
frame_start  out  1  1-cycle pulse when row 0 is presented

Behaviour:
- Reset values (asynchronous, rst=1):
  - prescaler=0, row_idx=0, front bank=0, swap pending=0, blink phase=0, frame count=0.
  - Both banks cleared to 0.
  - row = all inactive (all 1 if ROW_ACTIVE_LOW, else all 0); colr=colg=0; swap_ack=0; frame_start=0.
- Step tick: the prescaler counts 0..SCAN_DIV-1 and wraps; step = (prescaler==SCAN_DIV-1).
- Row advance: on step, row_idx advances 0..ROWS-1 and wraps to 0; a wrap is the frame boundary (frame tick).
- Outputs: registered, 1-cycle latency from row_idx.
  - row has a single active bit at position row_idx.
  - colr/colg = front[row_idx] colours, AND-ed with ~mask.
  - mask = blank | (blink_en & phase).
  - row stays active while masked; only the columns go dark.
- Write port:
  - When wr_en is high and wr_row < ROWS, back[wr_row] <= {wr_colr, wr_colg} at clk.
  - Writes never touch the front bank.
  - A write in the same cycle as a swap lands in the bank that was back before the flip, i.e. it becomes visible immediately after the swap.
- Swap handshake:
  - swap_req sets pending. A swap_req while pending is high is absorbed, so at most one swap happens per boundary.
  - On a frame tick with pending=1: the front bank flips and pending clears.
  - swap_ack pulses in the next cycle, and the first row of the new frame shows new data.
  - swap_req arriving in the same cycle as a frame tick with pending=0 is deferred to the next boundary.
- Blink:
  - The frame counter increments on each frame tick and wraps at BLINK_FRAMES-1; on that wrap, phase toggles.
  - While blink_en=0, the counter and phase are held at 0, so re-enabling always starts in the visible phase.
- frame_start: asserted in the same cycle the row output selects row 0.
- Reset mid-frame: pending swap discarded, frame contents lost, scanning restarts at row 0 after release.

Decomposition:
- Package dz_pkg holds:
  - the row-select polarity constant;
  - a function returning the one-hot row vector for an index and polarity;
  - a packed struct type for a row entry {colr, colg}.
- One sub-module, dz_scan_timer: prescaler, row counter, frame tick, and the blink counter/phase. Outputs step, row_idx, frame_tick and phase.
- The top level holds the two banks, the swap logic and the output registers.

Test Plan:
- Defaults, reset, no writes -> row cycles through 11111110, 11111101 ... 01111111 and repeats with period 8 clk; colr=colg=0; frame_start pulses every 8 clk, coincident with row=11111110.
- Write back[2]={0011_1100, 0111_1110} and no swap -> front still 0 at row 2. Then pulse swap_req mid-frame -> swap_ack exactly 1 clk after the next wrap; when row=11111011, colr=0011_1100 and colg=0111_1110.
- Two swap_req pulses within one frame -> exactly one swap_ack and one flip; the original front bank is now back and writable.
- BLINK_FRAMES=2, blink_en=1, front rows nonzero -> columns visible for frames 0-1, zero for frames 2-3, visible again for frames 4-5; row keeps scanning throughout.
- SCAN_DIV=4 -> each row held exactly 4 clk; frame period 32 clk. blank=1 -> colr/colg=0 starting from the next registered output cycle.
- Assert rst mid-frame with a swap pending -> all outputs take their reset values asynchronously; after release, no swap_ack ever appears and the banks read 0.
